// File: rtl/mem_stage.sv
// MEM-stage data memory: byte/half/word loads and stores to a local RAM, with fault detection and a sticky first-fault log.
// Define DMEM_STATS_EN to add the stat_loads/stat_stores/stat_faults counters.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_inst,
  input  logic [31:0] MEM_ALUresult,
  input  logic [31:0] MEM_busB,
  input  logic        MEM_MemWrite,
  input  logic        fault_clr,
  output logic [31:0] MEM_dout,
  output logic        MEM_fault,
  output logic        fault_valid,
  output logic [31:0] fault_pc,
  output logic [31:0] fault_addr
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_faults
`endif
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic [5:0]        opcode;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] widx;
  logic              is_load, is_store, is_half, is_word;
  logic              mem_access, misaligned, out_of_range, store_en;
  logic [31:0]       rword, wdata;
  logic [3:0]        be;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  // Zero at time zero; reset deliberately leaves contents alone.
  logic [31:0] ram [0:(1<<ADDR_W)-1] = '{default: 32'h0};

  assign opcode = MEM_inst[31:26];
  assign lane   = MEM_ALUresult[1:0];
  assign widx   = MEM_ALUresult[ADDR_W+1:2];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (opcode)
      OP_LB, OP_LBU:  is_load = 1'b1;
      OP_LH, OP_LHU:  begin is_load = 1'b1;  is_half = 1'b1; end
      OP_LW:          begin is_load = 1'b1;  is_word = 1'b1; end
      OP_SB:          is_store = 1'b1;
      OP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default:        ;
    endcase
  end

  // A store squashed by MemWrite=0 is a bubble: it neither accesses nor faults.
  assign mem_access   = is_load | (is_store & MEM_MemWrite);
  assign misaligned   = (is_half & lane[0]) | (is_word & (|lane));
  assign out_of_range = |MEM_ALUresult[31:ADDR_W+2];
  assign MEM_fault    = mem_access & (misaligned | out_of_range);
  assign store_en     = is_store & MEM_MemWrite & ~MEM_fault;

  assign rword = ram[widx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    MEM_dout = 32'h0;
    if (is_load && !MEM_fault) begin
      case (opcode)
        OP_LB:   MEM_dout = {{24{rbyte[7]}}, rbyte};
        OP_LBU:  MEM_dout = {24'h0, rbyte};
        OP_LH:   MEM_dout = {{16{rhalf[15]}}, rhalf};
        OP_LHU:  MEM_dout = {16'h0, rhalf};
        OP_LW:   MEM_dout = rword;
        default: MEM_dout = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte enables pick the live lane(s).
  always_comb begin
    be    = 4'b0000;
    wdata = MEM_busB;
    if (is_word) begin
      be = 4'b1111;
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{MEM_busB[15:0]}};
    end else begin
      be    = 4'b0001 << lane;
      wdata = {4{MEM_busB[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // First fault sticks; a fresh fault in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_pc    <= 32'h0;
      fault_addr  <= 32'h0;
    end else if (MEM_fault && (!fault_valid || fault_clr)) begin
      fault_valid <= 1'b1;
      fault_pc    <= MEM_pc;
      fault_addr  <= MEM_ALUresult;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
      fault_pc    <= 32'h0;
      fault_addr  <= 32'h0;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= 32'h0;
      stat_stores <= 32'h0;
      stat_faults <= 32'h0;
    end else begin
      if (is_load && !MEM_fault) stat_loads <= stat_loads + 32'h1;
      if (store_en)              stat_stores <= stat_stores + 32'h1;
      if (MEM_fault)             stat_faults <= stat_faults + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors plus randomized traffic against a byte-array reference model.
// Define DMEM_STATS_EN to also check the statistics counters.
module tb_mem_stage;
  localparam int ADDR_W = 10;
  localparam int BYTES  = 4 << ADDR_W;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, NOP = 6'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] MEM_pc = '0, MEM_inst = '0, MEM_ALUresult = '0, MEM_busB = '0;
  logic        MEM_MemWrite = 1'b0, fault_clr = 1'b0;
  logic [31:0] MEM_dout, fault_pc, fault_addr;
  logic        MEM_fault, fault_valid;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_faults;
  logic [31:0] m_loads, m_stores, m_faults;
`endif

  // Reference model state
  logic [7:0]  m_mem [BYTES];
  logic        m_fv;
  logic [31:0] m_fpc, m_faddr;
  logic [31:0] pc_ctr = 32'h0040_0000;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .MEM_pc(MEM_pc), .MEM_inst(MEM_inst),
    .MEM_ALUresult(MEM_ALUresult), .MEM_busB(MEM_busB), .MEM_MemWrite(MEM_MemWrite),
    .fault_clr(fault_clr), .MEM_dout(MEM_dout), .MEM_fault(MEM_fault),
    .fault_valid(fault_valid), .fault_pc(fault_pc), .fault_addr(fault_addr)
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
`endif
  );

  function automatic bit op_is_load(logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit op_is_store(logic [5:0] op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic bit exp_fault(logic [5:0] op, logic [31:0] a, logic we);
    int size;
    bit access;
    size = (op inside {LH, LHU, SH}) ? 2 : (op inside {LW, SW}) ? 4 : 1;
    access = op_is_load(op) || (op_is_store(op) && we);
    return access && ((a % size) != 0 || a >= BYTES);
  endfunction

  function automatic logic [31:0] exp_dout(logic [5:0] op, logic [31:0] a);
    int i;
    logic [15:0] h;
    if (!op_is_load(op) || exp_fault(op, a, 1'b0)) return 32'h0;
    i = int'(a);
    h = {m_mem[(i & ~1) + 1], m_mem[i & ~1]};
    case (op)
      LB:      return {{24{m_mem[i][7]}}, m_mem[i]};
      LBU:     return {24'h0, m_mem[i]};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
    endcase
  endfunction

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic clr, input logic r);
    @(negedge clk);
    MEM_inst      = {op, 26'($urandom)};
    MEM_ALUresult = a;
    MEM_busB      = d;
    MEM_MemWrite  = we;
    fault_clr     = clr;
    rst           = r;
    MEM_pc        = pc_ctr;
    pc_ctr        = pc_ctr + 32'd4;
    #1;
  endtask

  // Advance the model by one clock edge using the currently driven inputs, then let the DUT take the edge.
  task automatic step();
    logic [5:0] op;
    bit f;
    int i;
    op = MEM_inst[31:26];
    f  = exp_fault(op, MEM_ALUresult, MEM_MemWrite);
    if (rst) begin
      m_fv = 1'b0; m_fpc = '0; m_faddr = '0;
`ifdef DMEM_STATS_EN
      m_loads = '0; m_stores = '0; m_faults = '0;
`endif
    end else begin
      if (f && (!m_fv || fault_clr)) begin
        m_fv = 1'b1; m_fpc = MEM_pc; m_faddr = MEM_ALUresult;
      end else if (fault_clr) begin
        m_fv = 1'b0; m_fpc = '0; m_faddr = '0;
      end
      if (op_is_store(op) && MEM_MemWrite && !f) begin
        i = int'(MEM_ALUresult);
        if (op == SB) m_mem[i] = MEM_busB[7:0];
        else if (op == SH) {m_mem[i+1], m_mem[i]} = MEM_busB[15:0];
        else {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]} = MEM_busB;
      end
`ifdef DMEM_STATS_EN
      if (op_is_load(op) && !f) m_loads++;
      if (op_is_store(op) && MEM_MemWrite && !f) m_stores++;
      if (f) m_faults++;
`endif
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < BYTES; i++) m_mem[i] = 8'h0;
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive(LW, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fault_valid !== 1'b0 || fault_pc !== 32'h0 || fault_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_log: got v=%b pc=%h addr=%h expected 0/0/0", fault_valid, fault_pc, fault_addr);
    end
    n_checks++;
    if (MEM_dout !== 32'h0 || MEM_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ram: got dout=%h fault=%b expected 0/0", MEM_dout, MEM_fault);
    end
    step();
  endtask

  task automatic test_load_store();
    drive(SW, 32'h10, 32'h8070_6050, 1'b1, 1'b0, 1'b0); step();
    drive(LW, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h8070_6050) begin n_fail++; $display("FAIL lw_after_sw: got %h expected 80706050", MEM_dout); end
    step();
    drive(LB, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sign: got %h expected ffffff80", MEM_dout); end
    step();
    drive(LBU, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zero: got %h expected 00000080", MEM_dout); end
    step();
    drive(SB, 32'h11, 32'h0000_00AB, 1'b1, 1'b0, 1'b0); step();
    drive(LW, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h8070_AB50) begin n_fail++; $display("FAIL sb_lane: got %h expected 8070ab50", MEM_dout); end
    step();
    drive(SH, 32'h12, 32'hFFFF_1234, 1'b1, 1'b0, 1'b0); step();
    drive(LW, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h1234_AB50) begin n_fail++; $display("FAIL sh_lane: got %h expected 1234ab50", MEM_dout); end
    step();
    drive(LH, 32'h12, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_pos: got %h expected 00001234", MEM_dout); end
    step();
    drive(LHU, 32'h12, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h0000_1234) begin n_fail++; $display("FAIL lhu: got %h expected 00001234", MEM_dout); end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] pc_f;
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); step();
    drive(LW, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0);
    pc_f = MEM_pc;
    n_checks++;
    if (MEM_fault !== 1'b1 || MEM_dout !== 32'h0) begin
      n_fail++; $display("FAIL lw_misaligned: got fault=%b dout=%h expected 1/0", MEM_fault, MEM_dout);
    end
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (fault_valid !== 1'b1 || fault_addr !== 32'h6 || fault_pc !== pc_f) begin
      n_fail++; $display("FAIL log_first: got v=%b addr=%h pc=%h expected 1/6/%h", fault_valid, fault_addr, fault_pc, pc_f);
    end
    step();
    drive(SW, 32'h1000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (MEM_fault !== 1'b1 || fault_valid !== 1'b0) begin
      n_fail++; $display("FAIL sw_range: got fault=%b v=%b expected 1/0", MEM_fault, fault_valid);
    end
    step();
    drive(LB, 32'h2001, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_fault !== 1'b1 || fault_addr !== 32'h1000) begin
      n_fail++; $display("FAIL lb_range: got fault=%b addr=%h expected 1/1000", MEM_fault, fault_addr);
    end
    step();
    drive(LW, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h0 || fault_addr !== 32'h1000 || fault_valid !== 1'b1) begin
      n_fail++; $display("FAIL log_sticky: got dout=%h addr=%h v=%b expected 0/1000/1", MEM_dout, fault_addr, fault_valid);
    end
    step();
    drive(LW, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0); step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (fault_valid !== 1'b1 || fault_addr !== 32'h3) begin
      n_fail++; $display("FAIL clr_and_fault: got v=%b addr=%h expected 1/3", fault_valid, fault_addr);
    end
    step();
    drive(SW, 32'h1001, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fault_valid !== 1'b0 || fault_addr !== 32'h0 || fault_pc !== 32'h0 || MEM_fault !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone: got v=%b addr=%h pc=%h fault=%b expected 0/0/0/0", fault_valid, fault_addr, fault_pc, MEM_fault);
    end
    step();
    drive(SW, 32'h20, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1); step();
    drive(LW, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (MEM_dout !== 32'h0) begin n_fail++; $display("FAIL rst_blocks_sw: got %h expected 00000000", MEM_dout); end
    step();
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1); step();
    drive(LW, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0); step();
    drive(SW, 32'h40, 32'h5, 1'b1, 1'b0, 1'b0); step();
    drive(LB, 32'h41, 32'h0, 1'b0, 1'b0, 1'b0); step();
    drive(SB, 32'h43, 32'h7, 1'b1, 1'b0, 1'b0); step();
    drive(LHU, 32'h42, 32'h0, 1'b0, 1'b0, 1'b0); step();
    drive(LW, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0); step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (stat_loads !== 32'd3 || stat_stores !== 32'd2 || stat_faults !== 32'd1) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d/%0d expected 3/2/1", stat_loads, stat_stores, stat_faults);
    end
    step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1); step();
    drive(NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (stat_loads !== 32'd0 || stat_stores !== 32'd0 || stat_faults !== 32'd0) begin
      n_fail++; $display("FAIL stats_rst: got %0d/%0d/%0d expected 0/0/0", stat_loads, stat_stores, stat_faults);
    end
    step();
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [31:0] a;
    logic we, clr;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP};
    for (int n = 0; n < 400; n++) begin
      op  = ops[$urandom_range(0, 8)];
      a   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      we  = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 15) == 0);
      drive(op, a, $urandom, we, clr, 1'b0);
      n_checks++;
      if (MEM_fault !== exp_fault(op, a, we) || MEM_dout !== exp_dout(op, a)) begin
        n_fail++;
        $display("FAIL rand_access op=%h a=%h: got fault=%b dout=%h expected %b/%h",
                 op, a, MEM_fault, MEM_dout, exp_fault(op, a, we), exp_dout(op, a));
      end
      n_checks++;
      if (fault_valid !== m_fv || fault_pc !== m_fpc || fault_addr !== m_faddr) begin
        n_fail++;
        $display("FAIL rand_log: got v=%b pc=%h addr=%h expected %b/%h/%h",
                 fault_valid, fault_pc, fault_addr, m_fv, m_fpc, m_faddr);
      end
`ifdef DMEM_STATS_EN
      n_checks++;
      if (stat_loads !== m_loads || stat_stores !== m_stores || stat_faults !== m_faults) begin
        n_fail++;
        $display("FAIL rand_stats: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 stat_loads, stat_stores, stat_faults, m_loads, m_stores, m_faults);
      end
`endif
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_faults();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
